// File: rtl/network_mul_pkg.sv
// Shared widths, latency and the in-flight tag type for the shared
// multiplier arbiter and its DSP core.
package network_mul_pkg;

    localparam int MUL_A_W  = 16;
    localparam int MUL_B_W  = 15;
    localparam int MUL_P_W  = 30;
    localparam int MUL_LAT  = 2;
    localparam int MUL_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [MUL_ID_W-1:0] id;
    } mul_tag_t;

    // Sign-extend both operands to the product width so the multiply yields
    // exactly the low MUL_P_W bits of the true signed product.
    function automatic logic signed [MUL_P_W-1:0] mul_wrap(
        input logic signed [MUL_A_W-1:0] a,
        input logic signed [MUL_B_W-1:0] b
    );
        logic signed [MUL_P_W-1:0] a_x;
        logic signed [MUL_P_W-1:0] b_x;
        a_x = {{(MUL_P_W - MUL_A_W){a[MUL_A_W-1]}}, a};
        b_x = {{(MUL_P_W - MUL_B_W){b[MUL_B_W-1]}}, b};
        return a_x * b_x;
    endfunction

endpackage

// File: rtl/network_mul_share_arb_if.sv
// Requester and result handshake bundle of the shared multiplier.
interface network_mul_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    import network_mul_pkg::*;

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*MUL_A_W-1:0]   req_a;
    logic [NREQ*MUL_B_W-1:0]   req_b;
    logic                      res_valid;
    logic                      res_ready;
    logic [IDW-1:0]            res_id;
    logic signed [MUL_P_W-1:0] res_p;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_p
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_p
    );

endinterface

// File: rtl/network_mul_dsp_core.sv
// Two-stage signed 16x15 multiplier (operand reg + product reg), clock-enabled,
// product truncated to 30 bits.
module network_mul_dsp_core
    import network_mul_pkg::*;
(
    input  logic                      clk,
    input  logic                      ce,
    input  logic signed [MUL_A_W-1:0] a,
    input  logic signed [MUL_B_W-1:0] b,
    output logic signed [MUL_P_W-1:0] p
);

    logic signed [MUL_A_W-1:0] a_r;
    logic signed [MUL_B_W-1:0] b_r;

    // NOTE: datapath regs carry no reset; the tag pipe beside them says when they hold a live op.
    always_ff @(posedge clk) begin
        if (ce) begin
            a_r <= a;
            b_r <= b;
            p   <= mul_wrap(a_r, b_r);
        end
    end

endmodule

// File: rtl/network_mul_share_arb.sv
// Round-robin share of one pipelined multiplier between NREQ requesters, with
// a tag pipe tracking issuer ids and a backpressured result port.
module network_mul_share_arb
    import network_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    network_mul_share_arb_if.slave bus,
    output logic                   busy
);

    logic                      ce;
    logic                      found;
    logic [IDW-1:0]            ptr;
    logic [IDW-1:0]            grant_id;
    logic [NREQ-1:0]           grant;
    logic signed [MUL_A_W-1:0] a_sel;
    logic signed [MUL_B_W-1:0] b_sel;
    logic signed [MUL_P_W-1:0] core_p;
    mul_tag_t                  pipe [MUL_LAT];

    // A held result freezes the core, the tag pipe and the arbiter together.
    assign ce = !(pipe[MUL_LAT-1].valid && !bus.res_ready);

    always_comb begin
        int idx;
        // NOTE: every output of this block gets a default first so no latch is inferred.
        idx      = 0;
        found    = 1'b0;
        grant_id = '0;
        grant    = '0;
        a_sel    = '0;
        b_sel    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
                a_sel    = bus.req_a[idx*MUL_A_W +: MUL_A_W];
                b_sel    = bus.req_b[idx*MUL_B_W +: MUL_B_W];
            end
        end
        // Nothing is accepted while in reset, flushing or stalled.
        if (found && ce && !flush && reset_n) grant[grant_id] = 1'b1;
    end

    assign bus.req_ready = grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
            for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
        end else if (flush) begin
            ptr <= '0;
            for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
        end else if (ce) begin
            pipe[0].valid <= |grant;
            pipe[0].id    <= MUL_ID_W'(grant_id);
            for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
            if (|grant) ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    network_mul_dsp_core u_core (
        .clk (clk),
        .ce  (ce),
        .a   (a_sel),
        .b   (b_sel),
        .p   (core_p)
    );

    // Outputs read as zero whenever no live result is presented.
    assign bus.res_valid = pipe[MUL_LAT-1].valid;
    assign bus.res_id    = pipe[MUL_LAT-1].valid ? pipe[MUL_LAT-1].id[IDW-1:0] : '0;
    assign bus.res_p     = pipe[MUL_LAT-1].valid ? core_p : '0;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) busy = busy | pipe[i].valid;
    end

endmodule

// File: tb/tb_network_mul_share_arb.sv
// Randomized, scoreboarded bench for the shared multiplier arbiter: ops are
// modelled as a queue of issued products that age one step per enabled clock.
module tb_network_mul_share_arb;
    import network_mul_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        int                        id;
        logic signed [MUL_P_W-1:0] p;
        int                        age;
    } op_t;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    logic busy;

    network_mul_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    network_mul_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;
    int  m_ptr    = 0;
    int  n_push   = 0;
    int  dut_in   = 0;
    int  dut_out  = 0;
    int  a_v [NREQ];
    int  b_v [NREQ];
    op_t q [$];
    int  grant_log [$];
    int  res_log [$];

    function automatic logic signed [MUL_P_W-1:0] ref_mul(input int a, input int b);
        longint full;
        full = longint'(a) * longint'(b);
        return full[MUL_P_W-1:0];
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        a_v[i] = a;
        b_v[i] = b;
        bus.req_a[i*MUL_A_W +: MUL_A_W] = a[MUL_A_W-1:0];
        bus.req_b[i*MUL_B_W +: MUL_B_W] = b[MUL_B_W-1:0];
    endtask

    task automatic rand_op(input int i);
        set_op(i, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 32767)) - 16384);
    endtask

    // One clock: compare outputs with the model, then advance the model across the edge.
    task automatic tick();
        int              g;
        logic            vis;
        logic            ce_m;
        logic            exp_busy;
        logic [NREQ-1:0] exp_rdy;
        #1;
        vis      = (q.size() > 0) && (q[0].age >= MUL_LAT);
        exp_busy = (q.size() > 0);
        ce_m     = !(vis && !bus.res_ready);
        g        = (ce_m && !flush) ? exp_grant(bus.req_valid, m_ptr) : -1;
        exp_rdy  = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;

        checks++;
        if (bus.res_valid !== vis) begin
            failures++;
            $display("FAIL res_valid: got %b expected %b", bus.res_valid, vis);
        end
        if (vis) begin
            checks++;
            if (int'(bus.res_id) != q[0].id || bus.res_p !== q[0].p) begin
                failures++;
                $display("FAIL result: got id=%0d p=%0d expected id=%0d p=%0d",
                         bus.res_id, bus.res_p, q[0].id, q[0].p);
            end
        end
        checks++;
        if (bus.req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL req_ready: got %b expected %b", bus.req_ready, exp_rdy);
        end
        checks++;
        if (busy !== exp_busy) begin
            failures++;
            $display("FAIL busy: got %b expected %b", busy, exp_busy);
        end

        for (int i = 0; i < NREQ; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                dut_in++;
                grant_log.push_back(i);
            end
        if (bus.res_valid && bus.res_ready) begin
            dut_out++;
            res_log.push_back(int'(bus.res_id));
        end

        @(posedge clk);
        if (flush) begin
            q.delete();
            m_ptr = 0;
        end else if (ce_m) begin
            if (vis) void'(q.pop_front());
            foreach (q[j]) q[j].age++;
            if (g >= 0) begin
                q.push_back('{id: g, p: ref_mul(a_v[g], b_v[g]), age: 1});
                n_push++;
                m_ptr = (g + 1) % NREQ;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int n = 0; n < 10 && q.size() > 0; n++) tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d ops left expected 0", q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.req_ready !== '0 || busy !== 1'b0 ||
            bus.res_id !== '0 || bus.res_p !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b rdy=%b busy=%b id=%0d p=%0d expected all 0",
                     bus.res_valid, bus.req_ready, busy, bus.res_id, bus.res_p);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        set_op(0, 100, -3);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        #1;
        checks++;
        if (busy !== 1'b1 || bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_cycle1: got busy=%b v=%b expected busy=1 v=0", busy, bus.res_valid);
        end
        tick();
        #1;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_p !== -30'sd300 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_result: got v=%b id=%0d p=%0d busy=%b expected v=1 id=0 p=-300 busy=1",
                     bus.res_valid, bus.res_id, bus.res_p, busy);
        end
        tick();
        #1;
        checks++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got v=%b busy=%b expected 0 0", bus.res_valid, busy);
        end
    endtask

    task automatic test_fairness();
        grant_log.delete();
        res_log.delete();
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < NREQ; i++) rand_op(i);
            if (k >= 2) begin
                #1;
                checks++;
                if (bus.res_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL fair_throughput: cycle %0d got res_valid=%b expected 1", k, bus.res_valid);
                end
            end
            tick();
        end
        drain();
        // The single op from requester 0 leaves the pointer at 1.
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (k >= grant_log.size() || grant_log[k] != (1 + k) % NREQ) begin
                failures++;
                $display("FAIL fair_grant: slot %0d got %0d expected %0d", k,
                         (k < grant_log.size()) ? grant_log[k] : -1, (1 + k) % NREQ);
            end
            checks++;
            if (k >= res_log.size() || res_log[k] != (1 + k) % NREQ) begin
                failures++;
                $display("FAIL fair_res_id: slot %0d got %0d expected %0d", k,
                         (k < res_log.size()) ? res_log[k] : -1, (1 + k) % NREQ);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [MUL_P_W-1:0] hold_p;
        int start_push;
        dut_in     = 0;
        dut_out    = 0;
        start_push = n_push;
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            rand_op(2);
            tick();
        end
        hold_p = q[0].p;
        bus.res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_op(2);
            #1;
            checks++;
            if (bus.res_valid !== 1'b1 || bus.req_ready !== '0 || bus.res_id !== 2'd2 || bus.res_p !== hold_p) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d got v=%b rdy=%b id=%0d p=%0d expected v=1 rdy=0 id=2 p=%0d",
                         k, bus.res_valid, bus.req_ready, bus.res_id, bus.res_p, hold_p);
            end
            tick();
        end
        bus.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rand_op(2);
            tick();
        end
        drain();
        checks++;
        if (dut_in != n_push - start_push || dut_out != dut_in || dut_in != 8) begin
            failures++;
            $display("FAIL bp_count: got in=%0d out=%0d expected in=out=8", dut_in, dut_out);
        end
    endtask

    task automatic test_corners();
        int ca [3] = '{-32768, 32767, -32768};
        int cb [3] = '{16383, -16384, -16384};
        int cp [3] = '{-536838144, -536854528, -536870912};
        bus.res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int r;
            int n;
            r = int'($urandom_range(0, NREQ - 1));
            set_op(r, ca[k], cb[k]);
            bus.req_valid = '0;
            bus.req_valid[r] = 1'b1;
            tick();
            bus.req_valid = '0;
            n = 0;
            while (!bus.res_valid && n < 6) begin
                tick();
                n++;
            end
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_p !== cp[k]) begin
                failures++;
                $display("FAIL corner_%0d: got v=%b p=%0d expected v=1 p=%0d", k, bus.res_valid, bus.res_p, cp[k]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        bus.res_ready = 1'b1;
        rand_op(1);
        rand_op(3);
        bus.req_valid = 4'b1010;
        tick();
        tick();
        bus.res_ready = 1'b0;
        flush         = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        checks++;
        if (bus.req_ready !== '0) begin
            failures++;
            $display("FAIL flush_ready: got %b expected 0000", bus.req_ready);
        end
        tick();
        flush         = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL flush_empty: cycle %0d got v=%b busy=%b expected 0 0", k, bus.res_valid, busy);
            end
            tick();
        end
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) rand_op(i);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL flush_ptr: got %b expected 0001", bus.req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NREQ; i++) rand_op(i);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.req_ready !== '0 || busy !== 1'b0 ||
            bus.res_id !== '0 || bus.res_p !== '0) begin
            failures++;
            $display("FAIL reset_mid: got v=%b rdy=%b busy=%b id=%0d p=%0d expected all 0",
                     bus.res_valid, bus.req_ready, busy, bus.res_id, bus.res_p);
        end
        q.delete();
        m_ptr = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus.res_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_restart: got %b expected 0001", bus.req_ready);
        end
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NREQ; i++) rand_op(i);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NREQ; i++) rand_op(i);
            bus.req_valid = NREQ'($urandom_range(0, 15));
            bus.res_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_corners();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
